counter_ctrl: RTL and testbench
===============================

// Module: counter_ctrl
// PURPOSE
//  Sequencer for the WIDTH-bit up-counter datapath. Accepts start/pause/stop commands.
//  Latches a terminal count and drives the counter's clear and enable.
//  Reports busy, a one-cycle done pulse per terminal event, and a saturating wrap tally.
//  Sits between control logic and the counter_core instance it owns.
// PARAMETERS
//  WIDTH       5  counter / terminal-count width in bits
//  WRAP_W      8  width of saturating wrap tally
//  PRESCALE_W  4  prescaler width (used only with COUNTER_PRESCALE_EN)
// PORTS
//  clk            in   1           rising-edge clock
//  reset_n        in   1           asynchronous, active-low reset
//  start          in   1           begin a run (sampled in IDLE only)
//  pause          in   1           level; freeze counting while high (RUN/HOLD)
//  stop           in   1           abort to IDLE; highest priority
//  periodic       in   1           1 = auto-restart at terminal, 0 = one-shot (latched at start)
//  term_cnt       in   WIDTH       terminal value (latched at start)
//  prescale       in   PRESCALE_W  tick divider-1 (present only with COUNTER_PRESCALE_EN)
//  count          out  WIDTH       current counter value
//  busy           out  1           high in CLEAR, RUN, HOLD
//  done           out  1           1-cycle pulse on each terminal event
//  wrap_cnt       out  WRAP_W      terminal events since start, saturates at all-ones
// BEHAVIOUR
//  Reset (async, reset_n=0)
//   - state=IDLE; count=0, busy=0, done=0, wrap_cnt=0.
//   - Latched term/periodic=0; prescaler=0.
//   - Applies immediately, including mid-run.
//  States
//   - IDLE: start -> CLEAR; count holds last value.
//   - CLEAR (1 cycle): counter cleared to 0, wrap_cnt=0, prescaler=0; -> RUN, or -> HOLD if pause.
//   - RUN: each tick, if count!=term then count+1; if count==term then terminal event.
//   - HOLD: count and prescaler frozen; pause=0 -> RUN next cycle.
//  Terminal event
//   - done=1 in the following cycle; wrap_cnt increments, saturating.
//   - periodic=1: count->0 on the same tick, stay in RUN.
//   - periodic=0: count holds term; -> IDLE.
//  Priority
//   - stop > pause > tick. stop in any non-IDLE state -> IDLE next cycle, count held, no done.
//   - stop and terminal on the same cycle: stop wins, no done, wrap_cnt unchanged.
//  Boundaries
//   - term_cnt=0: terminal on every tick (periodic: done every tick).
//   - term_cnt=2^WIDTH-1: full range, no natural overflow.
//   - start while busy is ignored; term_cnt/periodic changes mid-run are ignored.
//   - Latency: start high at edge N -> CLEAR at N+1 -> first increment at edge N+2.
// CONFIGURATION
//  COUNTER_PRESCALE_EN defined
//   - prescale port exists.
//   - Tick fires once per (prescale+1) RUN cycles.
//   - Prescaler is zeroed in CLEAR and frozen in HOLD.
//   - prescale is sampled live, not latched.
//  Not defined
//   - No prescale port; tick=1 every RUN cycle.
// STRUCTURE
//  Shared package/header counter_defs
//   - state encodings IDLE/CLEAR/RUN/HOLD (2-bit), default WIDTH.
//  Sub-module counter_core
//   - (clk, reset_n, clr, en, q[WIDTH-1:0]).
//   - Synchronous clr has priority over en.
//  counter_ctrl holds the FSM, latches, prescaler and wrap tally; it drives clr/en of counter_core.
// TESTING
//  1. One-shot: term=5, periodic=0, start 1 cycle -> count 0..5, done pulses 1 cycle after count=5, busy drops, count holds 5.
//  2. Periodic: term=3, periodic=1 -> count 0,1,2,3,0,... ; done every 4 ticks; wrap_cnt=3 after 3 terminal events.
//  3. Pause: term=10, pause high at count=4 for 6 cycles -> count stays 4, busy stays 1; run resumes to 10.
//  4. Stop: stop at count=7 (term=20) -> IDLE next cycle, count holds 7, done never asserted. Stop on terminal cycle -> no done.
//  5. Mid-run reset: reset_n low at count=9 -> count, busy, done, wrap_cnt all 0 immediately; new start runs from 0.
//  6. Edges: term=0 periodic -> done every tick; term=31 one-shot -> 32 ticks. With PRESCALE_EN, prescale=2, term=2 -> increments every 3 cycles.

Source files
------------

// File: rtl/counter_defs.sv
// Shared definitions for the counter_ctrl sequencer and its counter_core datapath.
package counter_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_WIDTH  = 5;
  localparam int unsigned DEFAULT_WRAP_W = 8;

endpackage

// File: rtl/counter_core.sv
// WIDTH-bit up-counter datapath; synchronous clear takes priority over enable.
module counter_core
  import counter_defs::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Start/pause/stop sequencer for counter_core with terminal latch, done pulse and wrap tally.
// Optional tick prescaler is built when COUNTER_PRESCALE_EN is defined.
module counter_ctrl
  import counter_defs::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned WRAP_W = DEFAULT_WRAP_W
`ifdef COUNTER_PRESCALE_EN
  , parameter int unsigned PRESCALE_W = 4
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  stop,
  input  logic                  periodic,
  input  logic [WIDTH-1:0]      term_cnt,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic [WRAP_W-1:0]     wrap_cnt,
  output logic [1:0]            state_dbg
);

  state_t           state, state_next;
  logic [WIDTH-1:0] term_q;
  logic             periodic_q;
  logic             ctr_clr, ctr_en;
  logic             term_evt;
  logic             latch_en;
  logic             wrap_clr;
  logic             tick;

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (ctr_clr),
    .en     (ctr_en),
    .q      (count)
  );

  // Commands: stop beats pause beats tick in every busy state; start is only seen in IDLE.
  always_comb begin
    state_next = state;
    ctr_clr    = 1'b0;
    ctr_en     = 1'b0;
    term_evt   = 1'b0;
    latch_en   = 1'b0;
    wrap_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          latch_en   = 1'b1;
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else begin
          ctr_clr    = 1'b1;
          wrap_clr   = 1'b1;
          state_next = pause ? ST_HOLD : ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (pause) begin
          state_next = ST_HOLD;
        end else if (tick) begin
          if (count != term_q) begin
            ctr_en = 1'b1;
          end else begin
            term_evt = 1'b1;
            if (periodic_q) begin
              ctr_clr = 1'b1;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
      end
      ST_HOLD: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (!pause) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      term_q     <= '0;
      periodic_q <= 1'b0;
    end else if (latch_en) begin
      term_q     <= term_cnt;
      periodic_q <= periodic;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done <= 1'b0;
    end else begin
      done <= term_evt;
    end
  end

  // Tally sticks at all-ones once saturated until the next run clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_cnt <= '0;
    end else if (wrap_clr) begin
      wrap_cnt <= '0;
    end else if (term_evt && (wrap_cnt != {WRAP_W{1'b1}})) begin
      wrap_cnt <= wrap_cnt + 1'b1;
    end
  end

`ifdef COUNTER_PRESCALE_EN
  logic [PRESCALE_W-1:0] presc_q;
  logic                  presc_step;

  // prescale is live; >= keeps the divider sane if it is lowered mid-run.
  assign tick       = (presc_q >= prescale);
  assign presc_step = (state == ST_RUN) && !stop && !pause;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else if (state == ST_CLEAR) begin
      presc_q <= '0;
    end else if (presc_step) begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed plus randomized bench for counter_ctrl against a flag-based reference model.
module tb_counter_ctrl;

  localparam int WIDTH      = 5;
  localparam int WRAP_W     = 8;
  localparam int PRESCALE_W = 4;
  localparam int WRAP_MAX   = (1 << WRAP_W) - 1;

  // Clock/reset and stimulus signals
  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic start    = 1'b0;
  logic pause    = 1'b0;
  logic stop     = 1'b0;
  logic periodic = 1'b0;
  logic [WIDTH-1:0] term_cnt = '0;
`ifdef COUNTER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale = '0;
`endif

  logic [WIDTH-1:0]  count;
  logic              busy;
  logic              done;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [1:0]        state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_count, m_term, m_wrap, m_pcnt;
  bit m_busy, m_clearing, m_paused, m_per, m_done;

  always #5 clk = ~clk;

  counter_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .periodic (periodic),
    .term_cnt (term_cnt),
`ifdef COUNTER_PRESCALE_EN
    .prescale (prescale),
`endif
    .count    (count),
    .busy     (busy),
    .done     (done),
    .wrap_cnt (wrap_cnt),
    .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_term = 0; m_wrap = 0; m_pcnt = 0;
    m_busy = 0; m_clearing = 0; m_paused = 0; m_per = 0; m_done = 0;
  endtask

  task automatic model_step();
    bit tick;
    m_done = 1'b0;
    if (!m_busy) begin
      if (start && !stop) begin
        m_busy = 1; m_clearing = 1; m_term = int'(term_cnt); m_per = periodic;
      end
    end else if (stop) begin
      m_busy = 0; m_clearing = 0; m_paused = 0;
    end else if (m_clearing) begin
      m_clearing = 0; m_count = 0; m_wrap = 0; m_pcnt = 0; m_paused = pause;
    end else if (m_paused || pause) begin
      m_paused = pause;
    end else begin
`ifdef COUNTER_PRESCALE_EN
      tick   = (m_pcnt >= int'(prescale));
      m_pcnt = tick ? 0 : m_pcnt + 1;
`else
      tick = 1'b1;
`endif
      if (tick) begin
        if (m_count != m_term) begin
          m_count++;
        end else begin
          m_done = 1;
          if (m_wrap < WRAP_MAX) m_wrap++;
          if (m_per) m_count = 0;
          else m_busy = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    check("count", count, m_count);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("wrap_cnt", wrap_cnt, m_wrap);
    check("state_idle", state_dbg == 2'd0, !m_busy);
  endtask

  // One clock: model advances on the edge, DUT sampled on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic pulse_start(input int term, input bit per);
    term_cnt = WIDTH'(term);
    periodic = per;
    start    = 1'b1;
    cycle();
    start    = 1'b0;
    term_cnt = WIDTH'($urandom);
    periodic = $urandom_range(0, 1);
  endtask

  task automatic run_until_count(input int v, input int budget, input string tag);
    int n = 0;
    while (count != WIDTH'(v) && n < budget) begin
      cycle();
      n++;
    end
    check(tag, count, v);
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      cycle();
      n++;
    end
    check(tag, busy, 0);
  endtask

  initial begin
    int done_at, n_done, idle_at;

    // Reset state
    model_reset();
    #1;
    check_all();
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();

    // One-shot term=5
    pulse_start(5, 0);
    done_at = 0;
    for (int i = 2; i <= 12; i++) begin
      cycle();
      if (done && done_at == 0) done_at = i;
    end
    check("oneshot_done_edge", done_at, 8);
    check("oneshot_count_hold", count, 5);
    check("oneshot_busy", busy, 0);

    // Periodic term=3
    pulse_start(3, 1);
    n_done = 0;
    for (int i = 2; i <= 14; i++) begin
      cycle();
      if (done) n_done++;
    end
    check("periodic_dones", n_done, 3);
    check("periodic_wrap", wrap_cnt, 3);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    cycle();

    // Pause at count=4 for 6 cycles
    pulse_start(10, 0);
    run_until_count(4, 20, "pause_reach4");
    pause = 1'b1;
    repeat (6) cycle();
    check("pause_count", count, 4);
    check("pause_busy", busy, 1);
    pause = 1'b0;
    run_until_idle(30, "pause_finish");
    check("pause_final", count, 10);

    // Stop at count=7
    pulse_start(20, 0);
    run_until_count(7, 20, "stop_reach7");
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    n_done = 0;
    repeat (4) begin
      cycle();
      if (done) n_done++;
    end
    check("stop_count", count, 7);
    check("stop_busy", busy, 0);
    check("stop_no_done", n_done, 0);

    // Stop on the terminal cycle
    pulse_start(2, 0);
    run_until_count(2, 10, "stopterm_reach2");
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    n_done = (done) ? 1 : 0;
    repeat (3) begin
      cycle();
      if (done) n_done++;
    end
    check("stopterm_no_done", n_done, 0);
    check("stopterm_wrap", wrap_cnt, 0);

    // Mid-run asynchronous reset
    pulse_start(20, 0);
    run_until_count(9, 20, "reset_reach9");
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("reset_count0", count, 0);
    cycle();
    reset_n = 1'b1;
    pulse_start(4, 0);
    run_until_idle(20, "reset_rerun");
    check("reset_rerun_count", count, 4);

    // term=0 periodic: done every tick
    pulse_start(0, 1);
    cycle();
    n_done = 0;
    repeat (8) begin
      cycle();
      if (done) n_done++;
    end
    check("term0_dones", n_done, 8);
    stop = 1'b1;
    cycle();
    stop = 1'b0;

    // term=31 one-shot: 32 ticks after the clear
    pulse_start(31, 0);
    idle_at = 0;
    for (int i = 2; i <= 40; i++) begin
      cycle();
      if (!busy && idle_at == 0) idle_at = i;
    end
    check("term31_idle_edge", idle_at, 34);
    check("term31_count", count, 31);

`ifdef COUNTER_PRESCALE_EN
    // prescale=2: one increment every 3 RUN cycles
    prescale = 4'd2;
    pulse_start(2, 0);
    done_at = 0;
    for (int i = 2; i <= 14; i++) begin
      cycle();
      if (done && done_at == 0) done_at = i;
    end
    check("presc_done_edge", done_at, 11);
    prescale = '0;
`endif

    // Randomized command stream
    for (int i = 0; i < 400; i++) begin
      start    = ($urandom_range(0, 3) == 0);
      pause    = ($urandom_range(0, 7) == 0);
      stop     = ($urandom_range(0, 24) == 0);
      periodic = $urandom_range(0, 1);
      term_cnt = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 6));
`ifdef COUNTER_PRESCALE_EN
      prescale = PRESCALE_W'($urandom_range(0, 3));
`endif
      if ($urandom_range(0, 149) == 0) begin
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        cycle();
        reset_n = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
